// File: rtl/simple_pipe_pkg.sv
// ============================================================================
// simple_pipe_pkg : core update modes and per-channel next-state rule
// Revision 1.0
// ============================================================================
`default_nettype none

package simple_pipe_pkg;

   typedef enum logic [1:0] {
      TOGGLE  = 2'b00,
      SETHOLD = 2'b01,
      CAPTURE = 2'b10,
      CLEAR   = 2'b11
   } mode_e;

   // One channel of the core; p is the already-combined operand inp1 & inp2.
   function automatic logic core_next(input logic q, input logic p, input mode_e mode);
      logic nxt;
      nxt = q;
      case (mode)
         TOGGLE:  nxt = p & ~q;
         SETHOLD: nxt = q | p;
         CAPTURE: nxt = p;
         CLEAR:   nxt = 1'b0;
         default: nxt = q;
      endcase
      return nxt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/simple_pipe_stage.sv
// ============================================================================
// simple_pipe_stage : one elastic register slice with valid/ready handshake
// Revision 1.0
// ============================================================================
`default_nettype none

module simple_pipe_stage
   import simple_pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   input  logic             ready_i
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;

   // Ready is combinational from downstream so a full chain moves without bubbles.
   assign ready_o = ~valid_q | ready_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (ready_o) begin
         valid_d = valid_i;
         if (valid_i) begin
            data_d = data_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/simple_pipe.sv
// ============================================================================
// simple_pipe : WIDTH-channel selectable next-state core feeding a DEPTH-stage
//               elastic pipeline with registered occupancy count
// Revision 1.0
// ============================================================================
`default_nettype none

module simple_pipe
   import simple_pipe_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 9,
   parameter bit INVERT_OUT = 1'b0,
   parameter int OCC_W      = $clog2(DEPTH + 1)
) (
   input  logic             tau2015_clk,
   input  logic             tau2015_rst_n,
   input  logic [WIDTH-1:0] inp1,
   input  logic [WIDTH-1:0] inp2,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OCC_W-1:0] occupancy
);

   localparam logic [OCC_W-1:0] c_occ_one = OCC_W'(1);

   logic [WIDTH-1:0] core_q, core_d;
   logic [OCC_W-1:0] occ_q, occ_d;

   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_core_next;
   logic             w_accept;
   logic             w_pop;
   logic             w_valid [DEPTH+1];
   logic             w_ready [DEPTH+1];
   logic [WIDTH-1:0] w_data  [DEPTH+1];

   assign w_p      = inp1 & inp2;
   assign w_accept = in_valid & w_ready[0];
   assign w_pop    = w_valid[DEPTH] & out_ready;

   for (genvar c = 0; c < WIDTH; c++) begin : g_core
      assign w_core_next[c] = core_next(core_q[c], w_p[c], mode_e'(mode));
   end

   assign core_d = w_accept ? w_core_next : core_q;

   always_ff @(posedge tau2015_clk) begin
      if (!tau2015_rst_n) begin
         core_q <= '0;
      end else begin
         core_q <= core_d;
      end
   end

   // Stage 1 captures the freshly computed core value on the same edge the core updates.
   assign w_valid[0]     = in_valid;
   assign w_data[0]      = w_core_next ^ {WIDTH{INVERT_OUT}};
   assign w_ready[DEPTH] = out_ready;

   for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      simple_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk_i   (tau2015_clk),
         .rst_ni  (tau2015_rst_n),
         .valid_i (w_valid[s]),
         .data_i  (w_data[s]),
         .ready_o (w_ready[s]),
         .valid_o (w_valid[s+1]),
         .data_o  (w_data[s+1]),
         .ready_i (w_ready[s+1])
      );
   end

   always_comb begin
      occ_d = occ_q;
      case ({w_accept, w_pop})
         2'b10:   occ_d = occ_q + c_occ_one;
         2'b01:   occ_d = occ_q - c_occ_one;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge tau2015_clk) begin
      if (!tau2015_rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign in_ready  = w_ready[0];
   assign out       = w_data[DEPTH];
   assign out_valid = w_valid[DEPTH];
   assign occupancy = occ_q;

endmodule

`default_nettype wire

// File: tb/tb_simple_pipe.sv
// ============================================================================
// tb_simple_pipe : scoreboard bench for simple_pipe (WIDTH=4 DEPTH=3, and
//                  WIDTH=4 DEPTH=1 INVERT_OUT=1)
// ============================================================================
`default_nettype none

module tb_simple_pipe;
   import simple_pipe_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] inp1_a, inp2_a, out_a;
   logic [1:0] mode_a, occ_a;
   logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a;

   logic [3:0] inp1_b, inp2_b, out_b;
   logic [1:0] mode_b;
   logic [0:0] occ_b;
   logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b;

   simple_pipe #(.WIDTH(4), .DEPTH(3), .INVERT_OUT(1'b0)) u_dut_a (
      .tau2015_clk   (clk),
      .tau2015_rst_n (rst_n),
      .inp1          (inp1_a),
      .inp2          (inp2_a),
      .mode          (mode_a),
      .in_valid      (in_valid_a),
      .in_ready      (in_ready_a),
      .out           (out_a),
      .out_valid     (out_valid_a),
      .out_ready     (out_ready_a),
      .occupancy     (occ_a)
   );

   simple_pipe #(.WIDTH(4), .DEPTH(1), .INVERT_OUT(1'b1)) u_dut_b (
      .tau2015_clk   (clk),
      .tau2015_rst_n (rst_n),
      .inp1          (inp1_b),
      .inp2          (inp2_b),
      .mode          (mode_b),
      .in_valid      (in_valid_b),
      .in_ready      (in_ready_b),
      .out           (out_b),
      .out_valid     (out_valid_b),
      .out_ready     (out_ready_b),
      .occupancy     (occ_b)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [3:0] exp_a[$];
   logic [3:0] exp_b[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitors: a token transfers at the next rising edge when valid & ready here.
   always @(negedge clk) begin
      if (rst_n && out_valid_a && out_ready_a) begin
         if (exp_a.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL a_unexpected_token: got %0h, expected none", out_a);
         end else begin
            logic [3:0] e;
            e = exp_a.pop_front();
            check("a_out", {28'd0, out_a}, {28'd0, e});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid_b && out_ready_b) begin
         if (exp_b.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL b_unexpected_token: got %0h, expected none", out_b);
         end else begin
            logic [3:0] e;
            e = exp_b.pop_front();
            check("b_out", {28'd0, out_b}, {28'd0, e});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat_a(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] e);
      int waited;
      waited = 0;
      inp1_a = a; inp2_a = b; mode_a = m; in_valid_a = 1'b1;
      @(negedge clk);
      while (!in_ready_a && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready_a) begin
         n_vec++;
         n_err++;
         $display("FAIL a_accept_timeout: in_ready 0, expected 1");
      end else begin
         exp_a.push_back(e);
      end
      tick();
      in_valid_a = 1'b0;
   endtask

   task automatic drain_a();
      int c;
      c = 0;
      in_valid_a  = 1'b0;
      out_ready_a = 1'b1;
      while (exp_a.size() != 0 && c < 50) begin
         tick();
         c++;
      end
      check("a_drain_left", exp_a.size(), 0);
      check("a_drain_occ", {30'd0, occ_a}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      inp1_a = '0; inp2_a = '0; mode_a = TOGGLE; in_valid_a = 1'b0; out_ready_a = 1'b1;
      inp1_b = '0; inp2_b = '0; mode_b = TOGGLE; in_valid_b = 1'b0; out_ready_b = 1'b1;

      // Power-on reset
      repeat (2) tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out",       {28'd0, out_a}, 0);
      check("rst_out_valid", {31'd0, out_valid_a}, 0);
      check("rst_occ",       {30'd0, occ_a}, 0);
      check("rst_in_ready",  {31'd0, in_ready_a}, 1);
      check("rst_b_out",     {28'd0, out_b}, 0);
      check("rst_b_valid",   {31'd0, out_valid_b}, 0);
      tick();

      // Reset with two tokens in flight
      out_ready_a = 1'b0;
      beat_a(CAPTURE, 4'hF, 4'hF, 4'hF);
      beat_a(CAPTURE, 4'h3, 4'hF, 4'h3);
      @(negedge clk);
      check("mid_occ_before", {30'd0, occ_a}, 2);
      tick();
      rst_n = 1'b0;
      exp_a.delete();
      tick();
      check("mid_out",       {28'd0, out_a}, 0);
      check("mid_out_valid", {31'd0, out_valid_a}, 0);
      check("mid_occ",       {30'd0, occ_a}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_in_ready", {31'd0, in_ready_a}, 1);
      tick();
      out_ready_a = 1'b1;
      repeat (5) tick();

      // TOGGLE back-to-back: F,0,F,0, first out_valid two edges after accept
      for (int k = 0; k < 8; k++) begin
         if (k < 4) begin
            inp1_a = 4'hF; inp2_a = 4'hF; mode_a = TOGGLE; in_valid_a = 1'b1;
         end else begin
            in_valid_a = 1'b0;
         end
         @(negedge clk);
         if (k < 4) begin
            check("tog_in_ready", {31'd0, in_ready_a}, 1);
            exp_a.push_back((k % 2 == 0) ? 4'hF : 4'h0);
         end
         check("tog_out_valid", {31'd0, out_valid_a}, (k >= 3 && k <= 6) ? 1 : 0);
         tick();
      end
      drain_a();

      // Mode rules; mode is ignored while no beat is accepted
      beat_a(CAPTURE, 4'b1010, 4'b1100, 4'b1000);
      beat_a(SETHOLD, 4'b0001, 4'b0001, 4'b1001);
      mode_a = CLEAR; inp1_a = 4'hF; inp2_a = 4'hF;
      repeat (2) tick();
      beat_a(SETHOLD, 4'b0000, 4'b0000, 4'b1001);
      beat_a(CLEAR, 4'hF, 4'hF, 4'b0000);
      drain_a();

      // Backpressure: 5 offered beats, only 3 fit
      out_ready_a = 1'b0;
      idx = 1;
      for (int i = 0; i < 5; i++) begin
         inp1_a = idx[3:0]; inp2_a = 4'hF; mode_a = CAPTURE; in_valid_a = 1'b1;
         @(negedge clk);
         check("bp_in_ready", {31'd0, in_ready_a}, (i < 3) ? 1 : 0);
         if (in_ready_a) begin
            exp_a.push_back(idx[3:0]);
            idx++;
         end
         tick();
      end
      in_valid_a = 1'b0;
      check("bp_occ",       {30'd0, occ_a}, 3);
      check("bp_out_valid", {31'd0, out_valid_a}, 1);
      check("bp_out_held",  {28'd0, out_a}, 1);
      out_ready_a = 1'b1;
      while (idx <= 5) begin
         beat_a(CAPTURE, idx[3:0], 4'hF, idx[3:0]);
         idx++;
      end
      drain_a();

      // Simultaneous push and pop on a full pipe
      out_ready_a = 1'b0;
      beat_a(CAPTURE, 4'h6, 4'hF, 4'h6);
      beat_a(CAPTURE, 4'h7, 4'hF, 4'h7);
      beat_a(CAPTURE, 4'h8, 4'hF, 4'h8);
      @(negedge clk);
      check("full_occ",      {30'd0, occ_a}, 3);
      check("full_in_ready", {31'd0, in_ready_a}, 0);
      tick();
      out_ready_a = 1'b1;
      inp1_a = 4'h9; inp2_a = 4'hF; mode_a = CAPTURE; in_valid_a = 1'b1;
      @(negedge clk);
      check("pp_in_ready", {31'd0, in_ready_a}, 1);
      exp_a.push_back(4'h9);
      tick();
      in_valid_a  = 1'b0;
      out_ready_a = 1'b0;
      check("pp_occ", {30'd0, occ_a}, 3);
      check("pp_out", {28'd0, out_a}, 7);
      drain_a();

      // DEPTH=1, inverted output
      out_ready_b = 1'b0;
      inp1_b = 4'h5; inp2_b = 4'hF; mode_b = CAPTURE; in_valid_b = 1'b1;
      @(negedge clk);
      check("b_in_ready_empty", {31'd0, in_ready_b}, 1);
      exp_b.push_back(4'hA);
      tick();
      in_valid_b = 1'b0;
      @(negedge clk);
      check("b_out_direct",    {28'd0, out_b}, 4'hA);
      check("b_out_valid",     {31'd0, out_valid_b}, 1);
      check("b_in_ready_full", {31'd0, in_ready_b}, 0);
      check("b_occ_full",      {31'd0, occ_b}, 1);
      tick();
      out_ready_b = 1'b1;
      @(negedge clk);
      check("b_in_ready_drain", {31'd0, in_ready_b}, 1);
      tick();
      @(negedge clk);
      check("b_out_valid_after", {31'd0, out_valid_b}, 0);
      tick();

      check("a_left_end", exp_a.size(), 0);
      check("b_left_end", exp_b.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
